// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM wave generator slice.
// Holds the duty/period clamp limits, the default post-reset waveform, the
// scale engine state encoding and the engine step counts.
package pwm_pkg;

  localparam int unsigned DUTY_MAX   = 100;
  localparam int unsigned PERIOD_MIN = 2;
  localparam int unsigned RST_PERIOD = 250_000;
  localparam int unsigned RST_THRESH = 125_000;

  localparam int unsigned MUL_CYCLES = 8;
  localparam int unsigned DIV_CYCLES = 32;
  localparam int unsigned PROD_W     = 32;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StDone
  } eng_state_e;

endpackage

// File: rtl/pwm_scale_engine.sv
// Sequential scale engine: thresh = floor(period * duty / 100).
// An 8-step shift-add multiply is followed by a 32-step restoring divide by 100.
// A start pulse in any state (re)launches the multiply with fresh operands.
// Ports:
//   CLK, RSTn   clock, asynchronous active-low reset
//   start       launch/restart strobe, operands captured on this cycle
//   period      period operand (CLK cycles)
//   duty        duty operand (percent, already clamped)
//   thresh      computed high-time, valid while done is high
//   period_out  period that thresh belongs to, valid while done is high
//   done        one-cycle result strobe (registered)
//   busy        high during multiply and divide (registered)
module pwm_scale_engine
  import pwm_pkg::*;
#(
  parameter int unsigned PERIOD_W = 24,
  parameter int unsigned DUTY_W   = 8
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic                start,
  input  logic [PERIOD_W-1:0] period,
  input  logic [DUTY_W-1:0]   duty,
  output logic [PERIOD_W-1:0] thresh,
  output logic [PERIOD_W-1:0] period_out,
  output logic                done,
  output logic                busy
);

  eng_state_e          state_q;
  logic [4:0]          step_q;
  logic [PROD_W-1:0]   mcand_q;
  logic [DUTY_W-1:0]   mplier_q;
  logic [PROD_W-1:0]   acc_q;
  logic [PROD_W-1:0]   quo_q;
  logic [6:0]          rem_q;
  logic [PERIOD_W-1:0] op_period_q;

  logic [PROD_W-1:0] mul_add;
  logic [7:0]        div_trial;
  logic              div_ge;
  logic [6:0]        div_rem;
  logic [PROD_W-1:0] quo_n;

  // Remainder stays below 100, so 7 bits hold it and the shifted trial fits 8.
  always_comb begin
    mul_add   = mplier_q[0] ? acc_q + mcand_q : acc_q;
    div_trial = {rem_q, quo_q[PROD_W-1]};
    div_ge    = (div_trial >= 8'd100);
    div_rem   = div_ge ? 7'(div_trial - 8'd100) : div_trial[6:0];
    quo_n     = {quo_q[PROD_W-2:0], div_ge};
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= StIdle;
      step_q      <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      op_period_q <= '0;
      thresh      <= '0;
      period_out  <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        state_q     <= StMul;
        step_q      <= '0;
        mcand_q     <= PROD_W'(period);
        mplier_q    <= duty;
        acc_q       <= '0;
        op_period_q <= period;
        busy        <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: ;
          StMul: begin
            acc_q    <= mul_add;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            step_q   <= step_q + 5'd1;
            if (step_q == 5'(MUL_CYCLES - 1)) begin
              state_q <= StDiv;
              step_q  <= '0;
              quo_q   <= mul_add;
              rem_q   <= '0;
            end
          end
          StDiv: begin
            quo_q  <= quo_n;
            rem_q  <= div_rem;
            step_q <= step_q + 5'd1;
            if (step_q == 5'(DIV_CYCLES - 1)) begin
              state_q    <= StDone;
              busy       <= 1'b0;
              done       <= 1'b1;
              thresh     <= quo_n[PERIOD_W-1:0];
              period_out <= op_period_q;
            end
          end
          StDone: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: rtl/pwm_wave_generator.sv
// Glitch-free PWM generator. Clamped Duty/Count_P requests are change-detected,
// scaled to a high-time by pwm_scale_engine and held pending until the running
// period wraps, so a new setting never cuts a pulse short.
// Optional macro PWM_COMPLEMENT_EN adds the registered complement PWM_N_Out.
// Ports:
//   CLK, RSTn     clock, asynchronous active-low reset
//   Duty          requested duty in percent (>100 treated as 100)
//   Count_P       requested period in CLK cycles (<2 treated as 2)
//   PWM_Out       registered PWM waveform
//   Period_Start  registered one-cycle pulse at the first cycle of each period
//   Calc_Busy     high while the scale engine runs
//   PWM_N_Out     (PWM_COMPLEMENT_EN only) registered ~PWM_Out
module pwm_wave_generator #(
  parameter int unsigned PERIOD_W   = 24,
  parameter int unsigned DUTY_W     = 8,
  parameter int unsigned RST_PERIOD = pwm_pkg::RST_PERIOD,
  parameter int unsigned RST_THRESH = pwm_pkg::RST_THRESH
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic [DUTY_W-1:0]   Duty,
  input  logic [PERIOD_W-1:0] Count_P,
  output logic                PWM_Out,
  output logic                Period_Start,
  output logic                Calc_Busy
`ifdef PWM_COMPLEMENT_EN
  ,
  output logic                PWM_N_Out
`endif
);

  import pwm_pkg::*;

  logic [DUTY_W-1:0]   duty_c;
  logic [PERIOD_W-1:0] period_c;
  logic                change;
  logic                wrap;

  logic [DUTY_W-1:0]   req_duty_q;
  logic [PERIOD_W-1:0] req_period_q;
  logic                start_q;
  logic [PERIOD_W-1:0] cnt_q;
  logic [PERIOD_W-1:0] active_period_q;
  logic [PERIOD_W-1:0] active_thresh_q;
  logic [PERIOD_W-1:0] calc_period_q;
  logic [PERIOD_W-1:0] calc_thresh_q;
  logic                pending_q;

  logic [PERIOD_W-1:0] eng_thresh;
  logic [PERIOD_W-1:0] eng_period;
  logic                eng_done;

  always_comb begin
    duty_c   = (Duty > DUTY_W'(DUTY_MAX)) ? DUTY_W'(DUTY_MAX) : Duty;
    period_c = (Count_P < PERIOD_W'(PERIOD_MIN)) ? PERIOD_W'(PERIOD_MIN) : Count_P;
    change   = (duty_c != req_duty_q) || (period_c != req_period_q);
    wrap     = (cnt_q == active_period_q - PERIOD_W'(1));
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      req_duty_q   <= DUTY_W'(50);
      req_period_q <= PERIOD_W'(RST_PERIOD);
      start_q      <= 1'b0;
    end else begin
      start_q <= change;
      if (change) begin
        req_duty_q   <= duty_c;
        req_period_q <= period_c;
      end
    end
  end

  pwm_scale_engine #(
    .PERIOD_W (PERIOD_W),
    .DUTY_W   (DUTY_W)
  ) u_engine (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .start      (start_q),
    .period     (req_period_q),
    .duty       (req_duty_q),
    .thresh     (eng_thresh),
    .period_out (eng_period),
    .done       (eng_done),
    .busy       (Calc_Busy)
  );

  // A result finishing on the wrap cycle is not loaded there: the wrap takes the
  // older calc_* values and the fresh result waits for the next wrap.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt_q           <= '0;
      active_period_q <= PERIOD_W'(RST_PERIOD);
      active_thresh_q <= PERIOD_W'(RST_THRESH);
      calc_period_q   <= PERIOD_W'(RST_PERIOD);
      calc_thresh_q   <= PERIOD_W'(RST_THRESH);
      pending_q       <= 1'b0;
    end else begin
      if (wrap) begin
        cnt_q <= '0;
        if (pending_q) begin
          active_period_q <= calc_period_q;
          active_thresh_q <= calc_thresh_q;
        end
      end else begin
        cnt_q <= cnt_q + PERIOD_W'(1);
      end
      if (eng_done) begin
        calc_period_q <= eng_period;
        calc_thresh_q <= eng_thresh;
        pending_q     <= 1'b1;
      end else if (wrap) begin
        pending_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      PWM_Out      <= 1'b0;
      Period_Start <= 1'b0;
    end else begin
      PWM_Out      <= (cnt_q < active_thresh_q);
      Period_Start <= (cnt_q == '0);
    end
  end

`ifdef PWM_COMPLEMENT_EN
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      PWM_N_Out <= 1'b1;
    end else begin
      PWM_N_Out <= ~(cnt_q < active_thresh_q);
    end
  end
`endif

endmodule

// File: tb/tb_pwm_wave_generator.sv
// Scoreboard bench for pwm_wave_generator. A reference model, driven by the same
// inputs, predicts each cycle's outputs from the waveform rules (period phase,
// scheduled engine results, busy windows) and queues them; a monitor pops and
// compares on the falling edge. The reset waveform is shortened via parameters.
module tb_pwm_wave_generator;

  localparam int unsigned PW     = 24;
  localparam int unsigned DW     = 8;
  localparam int unsigned R_PER  = 40;
  localparam int unsigned R_THR  = 20;
  localparam int unsigned LAT    = 42;  // input sample edge -> result pending edge
  localparam int unsigned BUSY_N = 40;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] duty;
  logic [PW-1:0] count_p;
  logic          pwm_out;
  logic          period_start;
  logic          calc_busy;
`ifdef PWM_COMPLEMENT_EN
  logic          pwm_n_out;
`endif

  int tests;
  int fails;

  pwm_wave_generator #(
    .PERIOD_W   (PW),
    .DUTY_W     (DW),
    .RST_PERIOD (R_PER),
    .RST_THRESH (R_THR)
  ) dut (
    .CLK          (clk),
    .RSTn         (rst_n),
    .Duty         (duty),
    .Count_P      (count_p),
    .PWM_Out      (pwm_out),
    .Period_Start (period_start),
    .Calc_Busy    (calc_busy)
`ifdef PWM_COMPLEMENT_EN
    ,
    .PWM_N_Out    (pwm_n_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic pwm;
    logic ps;
    logic busy;
    int unsigned n;
  } exp_t;

  typedef struct {
    int unsigned due;
    int unsigned p;
    int unsigned t;
  } res_t;

  exp_t exp_q[$];
  res_t sched_q[$];

  int unsigned n_edge;
  int unsigned m_phase, m_act_p, m_act_t, m_pend_p, m_pend_t, m_req_d, m_req_p;
  int unsigned busy_lo, busy_hi;
  bit          m_pend, busy_vld;

  function automatic void model_reset();
    m_phase  = 0;
    m_act_p  = R_PER;
    m_act_t  = R_THR;
    m_pend   = 0;
    m_req_d  = 50;
    m_req_p  = R_PER;
    busy_vld = 0;
    sched_q.delete();
    exp_q.delete();
  endfunction

  initial begin
    n_edge = 0;
    model_reset();
  end

  // Reference model: one step per rising edge while out of reset.
  always @(posedge clk) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      exp_t        e;
      bit          wrap;
      int unsigned cd, cp;
      res_t        r;
      n_edge++;
      e.n    = n_edge;
      e.pwm  = (m_phase < m_act_t);
      e.ps   = (m_phase == 0);
      e.busy = busy_vld && (n_edge >= busy_lo) && (n_edge <= busy_hi);
      wrap   = (m_phase == m_act_p - 1);
      if (wrap && m_pend) begin
        m_act_p = m_pend_p;
        m_act_t = m_pend_t;
        m_pend  = 0;
      end
      if (sched_q.size() > 0 && sched_q[0].due == n_edge) begin
        m_pend   = 1;
        m_pend_p = sched_q[0].p;
        m_pend_t = sched_q[0].t;
        void'(sched_q.pop_front());
      end
      m_phase = wrap ? 0 : m_phase + 1;
      cd = (duty > 100) ? 100 : int'(duty);
      cp = (count_p < 2) ? 2 : int'(count_p);
      if (cd != m_req_d || cp != m_req_p) begin
        m_req_d = cd;
        m_req_p = cp;
        // Runs that have not reached their final cycle by the next edge are aborted.
        while (sched_q.size() > 0 && sched_q[sched_q.size()-1].due > n_edge + 1)
          void'(sched_q.pop_back());
        r.due = n_edge + LAT;
        r.p   = cp;
        r.t   = (cp * cd) / 100;
        sched_q.push_back(r);
        busy_lo  = n_edge + 1;
        busy_hi  = n_edge + BUSY_N;
        busy_vld = 1;
      end
      exp_q.push_back(e);
    end
  end

  task automatic check_bit(input string name, input int unsigned n, input logic act,
                           input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s edge=%0d got=%b exp=%b", name, n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_bit("pwm_out", e.n, pwm_out, e.pwm);
      check_bit("period_start", e.n, period_start, e.ps);
      check_bit("calc_busy", e.n, calc_busy, e.busy);
`ifdef PWM_COMPLEMENT_EN
      check_bit("pwm_n_out", e.n, pwm_n_out, ~e.pwm);
`endif
    end
  end

  task automatic apply(input int unsigned d, input int unsigned p, input int unsigned cycles);
    @(negedge clk);
    duty    = DW'(d);
    count_p = PW'(p);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_bit({tag, "_pwm"}, n_edge, pwm_out, 1'b0);
    check_bit({tag, "_ps"}, n_edge, period_start, 1'b0);
    check_bit({tag, "_busy"}, n_edge, calc_busy, 1'b0);
`ifdef PWM_COMPLEMENT_EN
    check_bit({tag, "_pwm_n"}, n_edge, pwm_n_out, 1'b1);
`endif
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    tests   = 0;
    fails   = 0;
    rst_n   = 1'b0;
    duty    = DW'(50);
    count_p = PW'(R_PER);
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (130) @(negedge clk);

    apply(30, 20, 200);                 // 6 high / 14 low after the load
    apply(0, 20, 100);                  // constant low
    apply(100, 20, 100);                // constant high, no gap
    apply(70, 30, 22);                  // aborted mid-run
    apply(40, 30, 200);                 // 12 high / 18 low
    apply(150, 0, 40);                  // clamped to period 2, duty 100

    for (int i = 0; i < 14; i++) begin
      apply($urandom_range(0, 130), $urandom_range(0, 45), $urandom_range(3, 120));
    end

    // Reset while the engine is dividing.
    apply(60, 25, 20);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    duty    = DW'(50);
    count_p = PW'(R_PER);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (130) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
